stack_control: RTL and testbench

STACK_CONTROL -- requirements
Module: stack_control

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_errcnt.sv | 28 ++
 rtl/stack_control.sv | 143 ++++++++++++++
 tb/tb_stack_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the stack controller: operation codes, FSM states
// and DATAOUT source selects.
package stack_pkg;

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_POP   = 3'b001;
  localparam logic [2:0] OP_TOP   = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
  localparam logic [2:0] OP_SUM   = 3'b100;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_READ = 2'd1,
    ST_LOOP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_MEM  = 2'b00,   // mem[HD-1-I]
    SEL_ACC  = 2'b01,   // DATAOUT + mem[HD-1-I]
    SEL_ZERO = 2'b10    // constant zero
  } dsel_t;

endpackage

// File: rtl/stack_errcnt.sv
// Saturating error counter: counts outcome writes flagged as errors and
// holds at all-ones.
module stack_errcnt #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/stack_control.sv
// Stack datapath controller. Decodes a latched op code into HD / I /
// memory / DATAOUT enables and a rdyin/ackout handshake per request.
// Optional feature: define STACK_CTRL_ERRCNT_EN to build the saturating
// error counter; otherwise err_cnt is tied to zero.
//
// state   | meaning
// WAIT    | idle, decode request when rdy=1
// READ    | POP/TOP: DATAOUT <= mem[HD-1], finish request
// LOOP    | SUM: accumulate until I == N, then finish request
module stack_control
  import stack_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int ERRCNT_W = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rdy,
  input  logic [OP_W-1:0]     op,
  input  logic                full,
  input  logic                empty,
  input  logic                eq,
  output logic                beta_hd,
  output logic                hd_dec,
  output logic                i_clr,
  output logic                i_inc,
  output logic                beta_mem,
  output logic                beta_dataout,
  output logic [1:0]          dataout_sel,
  output logic                beta_esito,
  output logic                esito_val,
  output logic                beta_rdyin,
  output logic                beta_ackout,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_cnt
);

  state_t state_q, state_d;
  logic   done, err;

  // Next state and enable decode; enables are held low while reset is
  // asserted so nothing reaches the datapath during reset.
  always_comb begin
    state_d      = state_q;
    beta_hd      = 1'b0;
    hd_dec       = 1'b0;
    i_clr        = 1'b0;
    i_inc        = 1'b0;
    beta_mem     = 1'b0;
    beta_dataout = 1'b0;
    dataout_sel  = SEL_MEM;
    done         = 1'b0;
    err          = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_WAIT: begin
          if (rdy) begin
            if (op == OP_W'(OP_PUSH)) begin
              done = 1'b1;
              if (!full) begin
                beta_mem = 1'b1;
                beta_hd  = 1'b1;
              end else begin
                err = 1'b1;
              end
            end else if ((op == OP_W'(OP_POP)) || (op == OP_W'(OP_TOP))) begin
              if (empty) begin
                done = 1'b1;
                err  = 1'b1;
              end else begin
                i_clr   = 1'b1;
                state_d = ST_READ;
              end
            end else if (op == OP_W'(OP_CLEAR)) begin
              // HD is zeroed in one step: beta_hd together with i_clr.
              done    = 1'b1;
              beta_hd = 1'b1;
              i_clr   = 1'b1;
            end else if (op == OP_W'(OP_SUM)) begin
              if (full) begin
                i_clr        = 1'b1;
                beta_dataout = 1'b1;
                dataout_sel  = SEL_ZERO;
                state_d      = ST_LOOP;
              end else begin
                done = 1'b1;
                err  = 1'b1;
              end
            end else begin
              done = 1'b1;
              err  = 1'b1;
            end
          end
        end
        ST_READ: begin
          beta_dataout = 1'b1;
          dataout_sel  = SEL_MEM;
          if (op == OP_W'(OP_POP)) begin
            beta_hd = 1'b1;
            hd_dec  = 1'b1;
          end
          done    = 1'b1;
          state_d = ST_WAIT;
        end
        ST_LOOP: begin
          if (!eq) begin
            beta_dataout = 1'b1;
            dataout_sel  = SEL_ACC;
            i_inc        = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
    beta_esito  = done;
    esito_val   = done & err;
    beta_rdyin  = done;
    beta_ackout = done;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_WAIT;
    else          state_q <= state_d;
  end

  assign busy = (state_q != ST_WAIT);

`ifdef STACK_CTRL_ERRCNT_EN
  stack_errcnt #(.W(ERRCNT_W)) u_errcnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (beta_esito & esito_val),
    .count   (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_stack_control.sv
// Bench for stack_control: directed requests push hand-computed expected
// outcomes into a queue; a negedge monitor accumulates enable activity per
// request and checks it against the queue head at each handshake.
module tb_stack_control;

  localparam int OP_W = 3;
  localparam int EW   = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rdy = 1'b0;
  logic [OP_W-1:0] op = '0;
  logic full = 1'b0, empty = 1'b0, eq = 1'b0;
  logic beta_hd, hd_dec, i_clr, i_inc, beta_mem, beta_dataout;
  logic [1:0] dataout_sel;
  logic beta_esito, esito_val, beta_rdyin, beta_ackout, busy;
  logic [EW-1:0] err_cnt;

  stack_control #(.OP_W(OP_W), .ERRCNT_W(EW)) dut (
    .clock(clock), .reset_n(reset_n), .rdy(rdy), .op(op), .full(full),
    .empty(empty), .eq(eq), .beta_hd(beta_hd), .hd_dec(hd_dec),
    .i_clr(i_clr), .i_inc(i_inc), .beta_mem(beta_mem),
    .beta_dataout(beta_dataout), .dataout_sel(dataout_sel),
    .beta_esito(beta_esito), .esito_val(esito_val),
    .beta_rdyin(beta_rdyin), .beta_ackout(beta_ackout), .busy(busy),
    .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string name;
    logic  esito, mem_w, hd_w, chk_dec, dec, clr;
    int    n_rd, n_sum, n_zero, cyc, err;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_fail = 0;
  int err_m = 0;
  int n_val = 0;
  int i_m = 0, i_next = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Environment model of the I register and the eq comparator.
  always @(posedge clock) begin
    #1;
    if (!reset_n) i_m = 0;
    else          i_m = i_next;
    eq = (i_m == n_val);
  end

  // Monitor: accumulate per-request activity, check at each handshake.
  logic a_mem, a_hd, a_dec, a_clr;
  int   a_rd, a_sum, a_zero, a_cyc;

  task automatic clr_acc();
    a_mem = 0; a_hd = 0; a_dec = 0; a_clr = 0;
    a_rd = 0; a_sum = 0; a_zero = 0; a_cyc = 0;
  endtask

  initial clr_acc();

  always @(negedge clock) begin
    exp_t x;
    i_next = i_clr ? 0 : (i_inc ? i_m + 1 : i_m);
    if (!reset_n) begin
      clr_acc();
    end else if (!rdy && !busy) begin
      chk("idle_enables", int'({beta_hd, i_clr, i_inc, beta_mem, beta_dataout,
                                beta_esito, beta_rdyin, beta_ackout}), 0);
    end else begin
      a_cyc++;
      if (beta_mem) a_mem = 1;
      if (beta_hd) begin a_hd = 1; a_dec = hd_dec; a_clr = i_clr; end
      if (beta_dataout && dataout_sel == 2'b00) a_rd++;
      if (beta_dataout && dataout_sel == 2'b01) a_sum++;
      if (beta_dataout && dataout_sel == 2'b10) a_zero++;
      if (beta_rdyin) begin
        chk("hs_ackout", int'(beta_ackout), 1);
        chk("hs_esito_we", int'(beta_esito), 1);
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_handshake: got ack expected none");
        end else begin
          x = sb.pop_front();
          chk({x.name, ".esito"}, int'(esito_val), int'(x.esito));
          chk({x.name, ".mem_w"}, int'(a_mem), int'(x.mem_w));
          chk({x.name, ".hd_w"}, int'(a_hd), int'(x.hd_w));
          if (x.hd_w && x.chk_dec) chk({x.name, ".hd_dec"}, int'(a_dec), int'(x.dec));
          if (x.hd_w) chk({x.name, ".hd_clr"}, int'(a_clr), int'(x.clr));
          chk({x.name, ".rd"}, a_rd, x.n_rd);
          chk({x.name, ".sum"}, a_sum, x.n_sum);
          chk({x.name, ".zero"}, a_zero, x.n_zero);
          chk({x.name, ".cycles"}, a_cyc, x.cyc);
          chk({x.name, ".err_cnt"}, int'(err_cnt), x.err);
        end
        clr_acc();
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] o, input logic f,
                       input logic e, input int n, input logic es,
                       input logic mw, input logic hw, input logic cd,
                       input logic dc, input logic cl, input int nrd,
                       input int nsum, input int nz, input int cy);
    exp_t x;
    bit got = 0;
    x.name = nm; x.esito = es; x.mem_w = mw; x.hd_w = hw; x.chk_dec = cd;
    x.dec = dc; x.clr = cl; x.n_rd = nrd; x.n_sum = nsum; x.n_zero = nz;
    x.cyc = cy; x.err = err_m;
    sb.push_back(x);
`ifdef STACK_CTRL_ERRCNT_EN
    if (es && err_m < 255) err_m++;
`endif
    @(posedge clock); #1;
    op = o; full = f; empty = e; n_val = n; rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (beta_rdyin) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s.timeout: got no handshake expected one within 40 cycles", nm);
      if (sb.size() != 0) void'(sb.pop_back());
    end
    @(posedge clock); #1;
    rdy = 1'b0;
  endtask

  initial begin
    // Reset: enables must stay low even with a request pending.
    rdy = 1'b1; op = 3'b000;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_beta_mem", int'(beta_mem), 0);
    chk("rst_ackout", int'(beta_ackout), 0);
    rdy = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    //     name          op     f  e  n  es mw hw cd dc cl rd sum z cyc
    issue("push",        3'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    issue("push_full",   3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue("pop",         3'd1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 2);
    issue("top",         3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    issue("pop_empty",   3'd1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue("top_empty",   3'd2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue("clear",       3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    issue("sum_n3",      3'd4, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 1, 5);
    issue("sum_n1",      3'd4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    issue("sum_notfull", 3'd4, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue("ill_5",       3'd5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue("ill_6",       3'd6, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue("ill_7",       3'd7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue("push_again",  3'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of a SUM: abandoned without any handshake.
    @(posedge clock); #1;
    op = 3'd4; full = 1'b1; n_val = 5; rdy = 1'b1;
    repeat (3) @(negedge clock);
    chk("mid_sum_busy", int'(busy), 1);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_loop_busy", int'(busy), 0);
    chk("rst_loop_ackout", int'(beta_ackout), 0);
    chk("rst_loop_dataout", int'(beta_dataout), 0);
    rdy = 1'b0;
    err_m = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("post_rst_err_cnt", int'(err_cnt), 0);
    chk("post_rst_busy", int'(busy), 0);
    repeat (4) @(posedge clock);

    // Saturation of the error counter.
    for (int k = 0; k < 256; k++) begin
      logic [2:0] o;
      o = 3'(5 + (k % 3));
      issue("ill_sat", o, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    @(posedge clock); #1;
`ifdef STACK_CTRL_ERRCNT_EN
    chk("err_saturated", int'(err_cnt), 255);
`else
    chk("err_disabled", int'(err_cnt), 0);
`endif
    issue("push_final",  3'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clock);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
